// File: rtl/circuit_a_sweep_ctrl.sv
// Sweeps CircuitA through all 16 input codes and presents each response on a valid/ready port.
// Optional feature macro: SWEEP_CHECKSUM_EN adds an 8-bit running checksum output of the responses.
module circuit_a_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] a_out,
  input  logic [3:0] b_in,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_code,
  output logic [3:0] res_data,
  output logic       busy,
  output logic       done
`ifdef SWEEP_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_code;
  logic [3:0] r_settleCnt;
  logic [3:0] r_aOut;
  logic [3:0] r_resCode;
  logic [3:0] r_resData;

  logic       w_load;
  logic       w_capture;
  logic       w_accept;
  logic       w_settleDone;
  logic       w_lastCode;
  logic [3:0] w_codeNext;

  assign w_settleDone = (r_state == SETTLE) && (r_settleCnt == LP_SETTLE);
  assign w_lastCode   = (r_code == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // abort takes precedence over both the settle timeout and a pending transfer
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_nextState = SETTLE;
          w_load      = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_settleDone) begin
          w_nextState = PRESENT;
          w_capture   = 1'b1;
        end
      end
      PRESENT: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (res_ready) begin
          w_accept    = 1'b1;
          w_nextState = w_lastCode ? DONE : SETTLE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_codeNext = r_code;
    if (w_load) begin
      w_codeNext = 4'd0;
    end else if (w_accept && !w_lastCode) begin
      w_codeNext = r_code + 4'd1;
    end
  end

  // Leaving IDLE starts the settle count at 0 so the first code settles one cycle longer,
  // giving CircuitA a full SETTLE_CYCLES after the sweep leaves its idle drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code      <= 4'd0;
      r_settleCnt <= 4'd0;
      r_aOut      <= 4'd0;
      r_resCode   <= 4'd0;
      r_resData   <= 4'd0;
    end else begin
      r_code <= w_codeNext;
      if (w_load) begin
        r_settleCnt <= 4'd0;
      end else if (w_accept && !w_lastCode) begin
        r_settleCnt <= 4'd1;
      end else if ((r_state == SETTLE) && !w_settleDone) begin
        r_settleCnt <= r_settleCnt + 4'd1;
      end
      if ((w_nextState == SETTLE) || (w_nextState == PRESENT)) begin
        r_aOut <= w_codeNext;
      end else begin
        r_aOut <= 4'd0;
      end
      if (w_capture) begin
        r_resCode <= r_code;
        r_resData <= b_in;
      end
    end
  end

`ifdef SWEEP_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= 8'd0;
    end else if (w_load) begin
      r_checksum <= 8'd0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + {4'd0, r_resData};
    end
  end

  assign checksum = r_checksum;
`endif

  assign a_out     = r_aOut;
  assign res_valid = (r_state == PRESENT);
  assign res_code  = r_resCode;
  assign res_data  = r_resData;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_circuit_a_sweep_ctrl.sv
// Directed bench for circuit_a_sweep_ctrl with a CircuitA stub (b = a ^ 4'b1010) and a transfer scoreboard.
module tb_circuit_a_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       res_ready;
  logic [3:0] a_out;
  logic [3:0] b_in;
  logic [3:0] res_code;
  logic [3:0] res_data;
  logic       res_valid;
  logic       busy;
  logic       done;
`ifdef SWEEP_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int         checks = 0;
  int         errors = 0;
  int         doneCount = 0;
  int         expDone = 0;
  logic [7:0] expQ[$];
  logic [7:0] monExp;

  always #5 clk = ~clk;

  assign b_in = a_out ^ 4'b1010;

  circuit_a_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .a_out    (a_out),
    .b_in     (b_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_code (res_code),
    .res_data (res_data),
    .busy     (busy),
    .done     (done)
`ifdef SWEEP_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r, input logic rdy);
    start     = s;
    abort     = a;
    rst       = r;
    res_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCodes(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      expQ.push_back({4'(c), 4'(c) ^ 4'hA});
    end
  endtask

  // Issues a one-cycle start pulse; returns at the edge that accepted it (+1).
  task automatic startSweep(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, "_busy"}, busy, 1'b1);
    checkOutput({tag, "_aout0"}, a_out, 4'd0);
`ifdef SWEEP_CHECKSUM_EN
    checkOutput({tag, "_cksum_clr"}, checksum, 8'h00);
`endif
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) break;
    end
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_done_aout"}, a_out, 4'd0);
    checkOutput({tag, "_done_valid"}, res_valid, 1'b0);
`ifdef SWEEP_CHECKSUM_EN
    checkOutput({tag, "_cksum"}, checksum, 8'h78);
`endif
    expDone++;
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, done, 1'b0);
    checkOutput({tag, "_idle_busy"}, busy, 1'b0);
    checkOutput({tag, "_sb_drain"}, expQ.size(), 0);
    tick();
  endtask

  task automatic waitSettleCode(input string tag, input logic [3:0] code);
    for (int i = 0; i < 200; i++) begin
      if ((a_out == code) && !res_valid && busy) break;
      tick();
    end
    checkOutput({tag, "_reach"}, a_out, code);
  endtask

  always @(negedge clk) begin
    if (done) doneCount++;
    if (!rst && !abort && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", expQ.size(), 1);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sb_code", res_code, monExp[7:4]);
        checkOutput("sb_data", res_data, monExp[3:0]);
        checkOutput("sb_aout", a_out, monExp[7:4]);
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("rst_aout", a_out, 4'd0);
    checkOutput("rst_valid", res_valid, 1'b0);
    checkOutput("rst_code", res_code, 4'd0);
    checkOutput("rst_data", res_data, 4'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    $display("[TB] start+abort together in IDLE");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_abort_busy", busy, 1'b0);
    tick();

    $display("[TB] full sweep, latency");
    pushCodes(0, 15);
    startSweep("sweep1");
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("lat_edge%0d", k), res_valid, logic'(k == 3));
    end
    waitDone("sweep1");

    $display("[TB] backpressure at code 7");
    pushCodes(0, 15);
    startSweep("sweep2");
    waitSettleCode("bp", 4'd7);
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_valid", k), res_valid, 1'b1);
      checkOutput($sformatf("hold%0d_code", k), res_code, 4'd7);
      checkOutput($sformatf("hold%0d_data", k), res_data, 4'hD);
      checkOutput($sformatf("hold%0d_aout", k), a_out, 4'd7);
      tick();
    end
    res_ready = 1'b1;
    waitDone("sweep2");

    $display("[TB] abort in PRESENT at code 4");
    pushCodes(0, 3);
    startSweep("sweep3");
    for (int i = 0; i < 200; i++) begin
      if (res_valid && (res_code == 4'd4)) break;
      tick();
    end
    checkOutput("abort_at_code", res_code, 4'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", res_valid, 1'b0);
    checkOutput("abort_aout", a_out, 4'd0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_sb", expQ.size(), 0);
    tick();
    tick();
    checkOutput("abort_no_done", doneCount, expDone);
    pushCodes(0, 15);
    startSweep("sweep4");
    waitDone("sweep4");

    $display("[TB] start while busy, then reset in SETTLE at code 9");
    pushCodes(0, 8);
    startSweep("sweep5");
    waitSettleCode("busy_start", 4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitSettleCode("rst", 4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_aout", a_out, 4'd0);
    checkOutput("mrst_valid", res_valid, 1'b0);
    checkOutput("mrst_code", res_code, 4'd0);
    checkOutput("mrst_data", res_data, 4'd0);
    checkOutput("mrst_busy", busy, 1'b0);
    checkOutput("mrst_done", done, 1'b0);
`ifdef SWEEP_CHECKSUM_EN
    checkOutput("mrst_cksum", checksum, 8'h00);
`endif
    checkOutput("mrst_sb", expQ.size(), 0);
    tick();
    tick();
    checkOutput("final_done_count", doneCount, expDone);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
